matmul_stream_engine: RTL and testbench
=======================================

Name: matmul_stream_engine

Overview:
Sequential signed matrix-multiply engine that consumes operand matrices as valid/ready element streams and produces the product matrix as a valid/ready result stream. It is the device end of the matmul bench flow: the bench generates A (n×m) and B (m×k) row-major, and this block loads, multiplies and returns C = A·B element by element. The datapath is a single multiply-accumulate (MAC) unit; it is not a systolic array.

Parameters:
DATA_WIDTH, 16, signed operand element width
MAX_DIM, 16, maximum legal value for each of n, m, k; sets buffer depth to MAX_DIM*MAX_DIM per operand
ACC_WIDTH, 2*DATA_WIDTH+$clog2(MAX_DIM), derived localparam; full-precision signed result width (36 at defaults)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle job request; honoured only in IDLE
dim_n, dim_m, dim_k  in  $clog2(MAX_DIM+1) each  A is n×m, B is m×k; sampled when start is accepted
in_valid  in  1  operand element valid
in_ready  out  1  engine accepts an operand element
in_data  in  DATA_WIDTH  signed operand element: A row-major, then B row-major
out_valid  out  1  result element valid
out_ready  in  1  downstream accepts the result
out_data  out  ACC_WIDTH  signed C[i][j], row-major
out_last  out  1  qualifies the final element C[n-1][k-1]
busy  out  1  high in every state except IDLE
err_dim  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset: all outputs 0, FSM enters IDLE, indices and accumulator cleared. Operand buffers are not cleared; their contents are don't-care.
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT.
- IDLE: on start, if any dimension is 0 or greater than MAX_DIM, pulse err_dim for 1 cycle and stay in IDLE. Otherwise latch the dimensions and go to LOAD_A.
- LOAD_A: in_ready=1. Each in_valid&&in_ready handshake writes A[r][c] in row-major order. The n*m-th handshake moves the FSM to LOAD_B.
- LOAD_B: identical behaviour for m*k elements, then move to COMPUTE with i=j=0.
- COMPUTE: the accumulator clears on entry. One MAC per cycle computes acc += A[i][p]*B[p][j] for p=0..m-1. After exactly m cycles go to OUTPUT.
- out_valid rises the cycle after the last MAC. The first result therefore appears m+1 cycles after the final B handshake.
- OUTPUT: out_valid=1, and out_data/out_last are held stable until out_ready. On handshake:
  - if (i,j) was the last element, go to IDLE, drop busy and drop out_valid;
  - otherwise advance j, wrapping to 0 with i+1, and return to COMPUTE.
- start while busy is ignored; no error is raised.
- in_ready=0 in IDLE, COMPUTE and OUTPUT. Input beats presented in those states are not consumed.
- Arithmetic: a full signed DATA_WIDTH×DATA_WIDTH product is sign-extended into an ACC_WIDTH accumulator. There is no saturation; the width is sized so the result cannot overflow.
- Reset mid-operation: the job is abandoned immediately and the block returns to the reset state.

Decomposition:
- matmul_pkg holds DATA_WIDTH, MAX_DIM, the ACC_WIDTH derivation, element_t (signed DATA_WIDTH), acc_t (signed ACC_WIDTH), dim_t and the state enum.
- Sub-module matmul_mac: registered signed MAC with clr and en inputs and an acc_t output. It is instantiated once.

Test Plan:
1. start with n=m=k=0 -> err_dim high for exactly 1 cycle; busy and in_ready stay 0. Repeat with n=17 at default MAX_DIM -> same response.
2. 1×1·1×1, A=3, B=-2 -> single beat: out_data=-6, out_last=1. busy falls the cycle after the handshake.
3. 2×2: A=[1 2;3 4], B=[5 6;7 8] -> beats 19, 22, 43, 50, with out_last asserted only on 50. The first out_valid occurs 3 cycles after the last B beat.
4. 2×3·3×2: A=[1 2 3;4 5 6], B=[7 8;9 10;11 12], out_ready held low 5 cycles on each beat -> 58, 64, 139, 154. out_data stays stable while stalled.
5. 16×16·16×16 with all elements -32768 -> all 256 beats equal 17179869184 (2^34), with no wrap.
6. Assert reset during LOAD_B, then release and run job 2 -> busy=0 and in_ready=0 right after reset; a following 1×1 job with A=5, B=7 returns 35.

Source files
------------

// File: rtl/matmul_pkg.sv
// Purpose: shared sizing, element/accumulator types and FSM encoding for the matmul stream engine.
// Contents: DATA_WIDTH, MAX_DIM, derived ACC_WIDTH, element_t, acc_t, dim_t, idx_t, addr_t, state_t, dim_ok().
// Importers: matmul_mac, matmul_stream_engine.
package matmul_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int MAX_DIM    = 16;
  // m products of 2*DATA_WIDTH bits each can grow the sum by $clog2(MAX_DIM) bits.
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(MAX_DIM);
  localparam int DIM_WIDTH  = $clog2(MAX_DIM + 1);
  localparam int IDX_WIDTH  = $clog2(MAX_DIM);
  // Buffers are addressed as {row, col} with a power-of-two row stride, so no
  // multiplier is needed for the address. At MAX_DIM=16 this is exactly 16*16.
  localparam int BUF_DEPTH  = 1 << (2 * IDX_WIDTH);

  typedef logic signed [DATA_WIDTH-1:0] element_t;
  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic [DIM_WIDTH-1:0]         dim_t;
  typedef logic [IDX_WIDTH-1:0]         idx_t;
  typedef logic [2*IDX_WIDTH-1:0]       addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_COMPUTE,
    ST_OUTPUT
  } state_t;

  // A dimension is usable when it is in 1..MAX_DIM.
  function automatic logic dim_ok(input dim_t d);
    return (d != '0) && (d <= dim_t'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Purpose: registered signed multiply-accumulate; acc <= acc + a*b when en, acc <= 0 when clr.
// Ports: clk, rst (async high), clr, en, a/b (element_t), acc (acc_t, registered).
// Latency: one cycle from en to updated acc; clr has priority over en.
module matmul_mac
  import matmul_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     en,
  input  element_t a,
  input  element_t b,
  output acc_t     acc
);

  acc_t                          acc_q;
  acc_t                          acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    // Full-precision signed product, then sign-extended into the accumulator.
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_stream_engine.sv
// Purpose: loads A (n x m) then B (m x k) from a valid/ready stream, computes C = A*B with one MAC,
//          and streams C row-major with out_last on the final element.
// Ports: clk, reset (async high), start + dim_n/m/k job request, in_* operand stream,
//        out_* result stream, busy, err_dim (one-cycle pulse on rejected start).
module matmul_stream_engine
  import matmul_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DIM_WIDTH-1:0]         dim_n,
  input  logic [DIM_WIDTH-1:0]         dim_m,
  input  logic [DIM_WIDTH-1:0]         dim_k,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err_dim
);

  state_t state_q, state_d;
  dim_t   n_q, n_d, m_q, m_d, k_q, k_d;
  idx_t   r_q, r_d, c_q, c_d;            // load write position (row, col)
  idx_t   i_q, i_d, j_q, j_d, p_q, p_d;  // output element (i, j) and dot-product step p
  logic   busy_q, busy_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   out_last_q, out_last_d;
  logic   err_dim_q, err_dim_d;

  logic   load_fire;
  logic   a_we, b_we;
  logic   mac_clr, mac_en;
  idx_t   last_i, last_p, last_j;
  acc_t   mac_acc;

  element_t a_mem [BUF_DEPTH];
  element_t b_mem [BUF_DEPTH];

  assign last_i = idx_t'(n_q - dim_t'(1));
  assign last_p = idx_t'(m_q - dim_t'(1));
  assign last_j = idx_t'(k_q - dim_t'(1));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    m_d        = m_q;
    k_d        = k_q;
    r_d        = r_q;
    c_d        = c_q;
    i_d        = i_q;
    j_d        = j_q;
    p_d        = p_q;
    out_last_d = out_last_q;
    err_dim_d  = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    load_fire  = in_valid && in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dim_ok(dim_n) && dim_ok(dim_m) && dim_ok(dim_k)) begin
            n_d     = dim_n;
            m_d     = dim_m;
            k_d     = dim_k;
            r_d     = '0;
            c_d     = '0;
            state_d = ST_LOAD_A;
          end else begin
            err_dim_d = 1'b1;
          end
        end
      end

      ST_LOAD_A: begin
        // A is n rows of m columns.
        if (load_fire) begin
          a_we = 1'b1;
          if (c_q == last_p) begin
            c_d = '0;
            if (r_q == last_i) begin
              r_d     = '0;
              state_d = ST_LOAD_B;
            end else begin
              r_d = r_q + idx_t'(1);
            end
          end else begin
            c_d = c_q + idx_t'(1);
          end
        end
      end

      ST_LOAD_B: begin
        // B is m rows of k columns.
        if (load_fire) begin
          b_we = 1'b1;
          if (c_q == last_j) begin
            c_d = '0;
            if (r_q == last_p) begin
              r_d     = '0;
              i_d     = '0;
              j_d     = '0;
              p_d     = '0;
              mac_clr = 1'b1;
              state_d = ST_COMPUTE;
            end else begin
              r_d = r_q + idx_t'(1);
            end
          end else begin
            c_d = c_q + idx_t'(1);
          end
        end
      end

      ST_COMPUTE: begin
        mac_en = 1'b1;
        if (p_q == last_p) begin
          p_d        = '0;
          out_last_d = (i_q == last_i) && (j_q == last_j);
          state_d    = ST_OUTPUT;
        end else begin
          p_d = p_q + idx_t'(1);
        end
      end

      ST_OUTPUT: begin
        // Accumulator is idle here, so out_data holds until the handshake.
        if (out_ready) begin
          out_last_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_IDLE;
          end else begin
            mac_clr = 1'b1;
            state_d = ST_COMPUTE;
            if (j_q == last_j) begin
              j_d = '0;
              i_d = i_q + idx_t'(1);
            end else begin
              j_d = j_q + idx_t'(1);
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered from the next state.
    busy_d      = (state_d != ST_IDLE);
    in_ready_d  = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    out_valid_d = (state_d == ST_OUTPUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      m_q         <= '0;
      k_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      p_q         <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_dim_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      m_q         <= m_d;
      k_q         <= k_d;
      r_q         <= r_d;
      c_q         <= c_d;
      i_q         <= i_d;
      j_q         <= j_d;
      p_q         <= p_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_dim_q   <= err_dim_d;
    end
  end

  // Operand buffers carry no reset; stale contents are never read before a full load.
  always_ff @(posedge clk) begin
    if (a_we) begin
      a_mem[{r_q, c_q}] <= element_t'(in_data);
    end
    if (b_we) begin
      b_mem[{r_q, c_q}] <= element_t'(in_data);
    end
  end

  matmul_mac u_mac (
    .clk (clk),
    .rst (reset),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (a_mem[{i_q, p_q}]),
    .b   (b_mem[{p_q, j_q}]),
    .acc (mac_acc)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mac_acc;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err_dim   = err_dim_q;

endmodule

// File: tb/tb_matmul_stream_engine.sv
module tb_matmul_stream_engine;
  import matmul_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic [DIM_WIDTH-1:0]        dim_n, dim_m, dim_k;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        out_last;
  logic                        busy;
  logic                        err_dim;

  int checks = 0;
  int errors = 0;
  int a_arr [256];
  int b_arr [256];

  matmul_stream_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dim_n     (dim_n),
    .dim_m     (dim_m),
    .dim_k     (dim_k),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err_dim   (err_dim)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int x, input int gaps);
    logic [31:0] v;
    int t;
    v = x;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      step();
    end
    in_valid = 1'b1;
    in_data  = v[DATA_WIDTH-1:0];
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Reference: C[r][c] = sum_p A[r][p]*B[p][c], plain integer arithmetic.
  function automatic longint ref_c(input int n, input int m, input int k, input int r, input int c);
    longint s = 0;
    for (int p = 0; p < m; p++) s += longint'(a_arr[r*m+p]) * longint'(b_arr[p*k+c]);
    return s;
  endfunction

  task automatic reject(input int n, input int m, input int k);
    dim_n = DIM_WIDTH'(n);
    dim_m = DIM_WIDTH'(m);
    dim_k = DIM_WIDTH'(k);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_dim_pulse", {63'd0, err_dim}, 64'd1);
    chk("err_busy", {63'd0, busy}, 64'd0);
    chk("err_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("err_dim_drop", {63'd0, err_dim}, 64'd0);
    chk("err_busy2", {63'd0, busy}, 64'd0);
    chk("err_in_ready2", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic run_job(input int n, input int m, input int k,
                         input int stall_min, input int stall_max,
                         input int max_gap, input bit poke_start);
    int lat, t, stall;
    longint expv;
    logic signed [ACC_WIDTH-1:0] held;
    dim_n = DIM_WIDTH'(n);
    dim_m = DIM_WIDTH'(m);
    dim_k = DIM_WIDTH'(k);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("no_err_valid_start", {63'd0, err_dim}, 64'd0);
    for (int e = 0; e < n*m; e++) send(a_arr[e], $urandom_range(0, max_gap));
    if (poke_start) begin
      // A start (even an illegal one) while busy must be ignored silently.
      dim_n = '0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_while_busy_err", {63'd0, err_dim}, 64'd0);
      chk("start_while_busy_busy", {63'd0, busy}, 64'd1);
    end
    for (int e = 0; e < m*k; e++) send(b_arr[e], $urandom_range(0, max_gap));
    // Now just past the edge that took the last B beat; m MAC cycles follow,
    // so out_valid is seen after m further edges (m+1 cycles after the beat).
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    chk("first_result_latency", 64'(lat), 64'(m));
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < k; c++) begin
        t = 0;
        while (out_valid !== 1'b1 && t < 200) begin
          step();
          t++;
        end
        if (t >= 200) chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
        chk("in_ready_in_output", {63'd0, in_ready}, 64'd0);
        expv = ref_c(n, m, k, r, c);
        chk("out_data", 64'($signed(out_data)), 64'(expv));
        chk("out_last", {63'd0, out_last}, {63'd0, (r == n-1) && (c == k-1)});
        stall = $urandom_range(stall_min, stall_max);
        held  = out_data;
        for (int s = 0; s < stall; s++) begin
          in_valid = 1'b1;                 // junk beat that must not be taken
          in_data  = DATA_WIDTH'($urandom);
          step();
          chk("stall_data_stable", 64'($signed(out_data)), 64'($signed(held)));
          chk("stall_valid_held", {63'd0, out_valid}, 64'd1);
          chk("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
      end
    end
    chk("busy_after_last", {63'd0, busy}, 64'd0);
    chk("valid_after_last", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int n, m, k;
    reset     = 1'b1;
    start     = 1'b0;
    dim_n     = '0;
    dim_m     = '0;
    dim_k     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_err_dim", {63'd0, err_dim}, 64'd0);
    chk("rst_out_data", 64'($signed(out_data)), 64'd0);
    reset = 1'b0;
    step();

    // Illegal dimensions.
    reject(0, 0, 0);
    reject(17, 1, 1);
    reject(1, 1, 0);

    // 1x1 * 1x1.
    a_arr[0] = 3;
    b_arr[0] = -2;
    run_job(1, 1, 1, 0, 0, 0, 1'b0);

    // 2x2 * 2x2.
    a_arr[0:3] = '{1, 2, 3, 4};
    b_arr[0:3] = '{5, 6, 7, 8};
    run_job(2, 2, 2, 0, 0, 0, 1'b0);

    // 2x3 * 3x2 with a 5-cycle stall on every result.
    a_arr[0:5] = '{1, 2, 3, 4, 5, 6};
    b_arr[0:5] = '{7, 8, 9, 10, 11, 12};
    run_job(2, 3, 2, 5, 5, 1, 1'b1);

    // Random shapes and data.
    for (int job = 0; job < 4; job++) begin
      n = $urandom_range(1, 4);
      m = $urandom_range(1, 5);
      k = $urandom_range(1, 4);
      for (int e = 0; e < n*m; e++) a_arr[e] = int'($urandom_range(0, 65535)) - 32768;
      for (int e = 0; e < m*k; e++) b_arr[e] = int'($urandom_range(0, 65535)) - 32768;
      run_job(n, m, k, 0, 3, 2, job[0]);
    end

    // Full size, most negative operands: every result is 16 * 2^30 = 2^34.
    for (int e = 0; e < 256; e++) begin
      a_arr[e] = -32768;
      b_arr[e] = -32768;
    end
    run_job(16, 16, 16, 0, 0, 0, 1'b0);

    // Reset in the middle of LOAD_B abandons the job.
    a_arr[0:3] = '{1, 1, 1, 1};
    dim_n = 5'd2;
    dim_m = 5'd2;
    dim_k = 5'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 0; e < 5; e++) send(1, 0);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    step();
    reset = 1'b0;
    step();
    a_arr[0] = 5;
    b_arr[0] = 7;
    run_job(1, 1, 1, 0, 2, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
